// File: rtl/neuron_accumulator.sv
// neuron_accumulator
//   Sums N_INPUTS sign-magnitude Q5.10 products for one neuron on top of a
//   per-neuron bias. The sum is kept in a wide two's-complement accumulator.
//   The result is saturated and returned as sign-magnitude Q5.10 through a
//   valid/ready output handshake.
//   Optional feature macro: RELU_EN clamps negative sums to zero before the
//   output is formed. When it is not defined, signed results pass through.
module neuron_accumulator #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic [15:0] prod_in,
    input  logic        prod_valid,
    output logic        in_ready,
    output logic        busy,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int              CNT_W    = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [15:0]              out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;

    // Sign-magnitude Q5.10 to accumulator width; -0 naturally maps to 0.
    function automatic logic signed [ACC_W-1:0] sm_to_acc(input logic [15:0] x);
        logic signed [ACC_W-1:0] mag;
        mag = signed'({{(ACC_W-15){1'b0}}, x[14:0]});
        return x[15] ? -mag : mag;
    endfunction

    // Optional rectification of the finished sum.
    function automatic logic signed [ACC_W-1:0] apply_relu(input logic signed [ACC_W-1:0] r);
`ifdef RELU_EN
        return (r < 0) ? '0 : r;
`else
        return r;
`endif
    endfunction

    // Saturate the magnitude to 15 bits and rebuild a sign-magnitude word.
    // The accumulator width bound keeps -r representable, so no wrap here.
    function automatic logic [15:0] acc_to_sm(input logic signed [ACC_W-1:0] r);
        logic             neg;
        logic [ACC_W-1:0] mag;
        neg = r[ACC_W-1];
        mag = neg ? unsigned'(-r) : unsigned'(r);
        if (mag > ACC_W'(15'h7FFF)) begin
            return {neg, 15'h7FFF};
        end
        return {neg, mag[14:0]};
    endfunction

    // Next-state and datapath updates for the four-state neuron sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = sm_to_acc(bias);
                    count_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    acc_d   = acc_q + sm_to_acc(prod_in);
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                out_data_d  = acc_to_sm(apply_relu(acc_q));
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        // Back-to-back neuron: skip IDLE, load the new bias now.
                        acc_d   = sm_to_acc(bias);
                        count_d = '0;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any neuron in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator
//   Directed and randomized bench for neuron_accumulator with N_INPUTS=4.
//   Expected results come from integer arithmetic on the decoded Q5.10 values.
module tb_neuron_accumulator;

    localparam int N   = 4;
    localparam int ACW = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = '0;
    logic [15:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        in_ready;
    logic        busy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    neuron_accumulator #(.N_INPUTS(N), .ACC_W(ACW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: decode to integers, sum, optional ReLU, saturate, re-encode.
    function automatic int sm2int(input logic [15:0] x);
        return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    endfunction

    function automatic logic [15:0] ref_result(input logic [15:0] b, input logic [15:0] p [N]);
        int  s;
        int  m;
        logic neg;
        s = sm2int(b);
        for (int i = 0; i < N; i++) s += sm2int(p[i]);
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        neg = (s < 0);
        m = neg ? -s : s;
        if (m > 32767) m = 32767;
        return {neg, 15'(m)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 16'($urandom);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Present one product after up to max_gap idle cycles with garbage data.
    task automatic feed(input logic [15:0] p, input int max_gap);
        int gaps;
        gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        for (int g = 0; g < gaps; g++) begin
            prod_valid = 1'b0;
            prod_in    = 16'($urandom);
            tick();
            check("gap_in_ready", 32'(in_ready), 32'd1);
        end
        prod_valid = 1'b1;
        prod_in    = p;
        tick();
        prod_valid = 1'b0;
        prod_in    = 16'($urandom);
    endtask

    // Called right after the last accept edge: FINISH now, result one edge later.
    task automatic finish_check(input string tag, input logic [15:0] exp);
        check({tag, "_finish_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_finish_in_ready"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("accept_valid", 32'(out_valid), 32'd0);
        check("accept_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_neuron(input string tag, input logic [15:0] b,
                              input logic [15:0] p [N], input logic [15:0] exp, input int max_gap);
        do_start(b);
        for (int i = 0; i < N; i++) feed(p[i], max_gap);
        finish_check(tag, exp);
    endtask

    logic [15:0] pv [N];
    logic [15:0] held;

    initial begin
        // Reset state
        #23;
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #4 reset = 1'b1;
        tick();

        // prod_valid in IDLE must be ignored
        prod_valid = 1'b1;
        prod_in    = 16'h0400;
        tick();
        prod_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);

        // 1: four times +1.0
        pv = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_neuron("t1", 16'h0000, pv, 16'h1000, 0);
        accept_out();

        // 2: sum -1.0 including a -0 product
        pv = '{16'h0400, 16'h8800, 16'h0400, 16'h8000};
`ifdef RELU_EN
        run_neuron("t2", 16'h8400, pv, 16'h0000, 0);
`else
        run_neuron("t2", 16'h8400, pv, 16'h8400, 0);
`endif
        accept_out();

        // 3: positive and negative saturation
        pv = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00};
        run_neuron("t3p", 16'h0000, pv, 16'h7FFF, 0);
        accept_out();
        pv = '{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
`ifdef RELU_EN
        run_neuron("t3n", 16'h0000, pv, 16'h0000, 0);
        held = 16'h0000;
`else
        run_neuron("t3n", 16'h0000, pv, 16'hFFFF, 0);
        held = 16'hFFFF;
`endif

        // 4: HOLD with out_ready low and prod_valid toggling
        for (int c = 0; c < 5; c++) begin
            prod_valid = ~prod_valid;
            prod_in    = 16'h0400;
            tick();
            check("t4_data", 32'(out_data), 32'(held));
            check("t4_valid", 32'(out_valid), 32'd1);
            check("t4_in_ready", 32'(in_ready), 32'd0);
        end
        prod_valid = 1'b0;

        // 5: accept and restart in the same HOLD cycle, gappy products
        out_ready = 1'b1;
        start     = 1'b1;
        bias      = 16'h0800;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_valid", 32'(out_valid), 32'd0);
        pv = '{16'h0400, 16'h8C00, 16'h0200, 16'h0100};
        for (int i = 0; i < N; i++) feed(pv[i], 3);
        finish_check("t5", ref_result(16'h0800, pv));
        accept_out();

        // 6: reset after two products, then a clean neuron
        do_start(16'h0000);
        feed(16'h0400, 0);
        feed(16'h0400, 0);
        reset = 1'b0;
        #2;
        check("t6_out_data", 32'(out_data), 32'h0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        pv = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_neuron("t6", 16'h0000, pv, 16'h1000, 0);
        accept_out();

        // Randomized neurons against the integer model
        for (int t = 0; t < 40; t++) begin
            logic [15:0] b;
            b = {1'($urandom), 15'($urandom_range(0, 16'h1FFF))};
            for (int i = 0; i < N; i++) begin
                if (t % 3 == 0) pv[i] = 16'($urandom);
                else            pv[i] = {1'($urandom), 15'($urandom_range(0, 16'h0FFF))};
            end
            run_neuron("rnd", b, pv, ref_result(b, pv), 2);
            held = ref_result(b, pv);
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                tick();
                check("rnd_hold_data", 32'(out_data), 32'(held));
            end
            accept_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
